// File: rtl/knap_pkg.sv
// Shared constants, item tables and FSM state type for the Gray-code knapsack enumerator.
package knap_pkg;

  localparam int N_ITEMS = 16;
  localparam int W       = 8;
  localparam int ACC_W   = W + $clog2(N_ITEMS);
  localparam int POS_W   = $clog2(N_ITEMS);

  localparam logic [ACC_W-1:0] MIN_VALUE_DEF  = ACC_W'(120);
  localparam logic [ACC_W-1:0] MAX_WEIGHT_DEF = ACC_W'(60);
  localparam logic [ACC_W-1:0] MAX_VOLUME_DEF = ACC_W'(60);

  // Element k of each table belongs to item k (mask bit k).
  localparam logic [W-1:0] VALUE_TAB [N_ITEMS] =
    '{8'd4, 8'd8, 8'd0, 8'd20, 8'd10, 8'd12, 8'd18, 8'd14,
      8'd6, 8'd15, 8'd30, 8'd8, 8'd16, 8'd18, 8'd18, 8'd14};
  localparam logic [W-1:0] WEIGHT_TAB [N_ITEMS] =
    '{8'd28, 8'd8, 8'd27, 8'd18, 8'd27, 8'd28, 8'd6, 8'd1,
      8'd20, 8'd0, 8'd5, 8'd13, 8'd8, 8'd14, 8'd22, 8'd12};
  localparam logic [W-1:0] VOLUME_TAB [N_ITEMS] =
    '{8'd27, 8'd27, 8'd4, 8'd4, 8'd0, 8'd24, 8'd4, 8'd20,
      8'd12, 8'd15, 8'd5, 8'd2, 8'd9, 8'd28, 8'd19, 8'd18};

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  function automatic logic [N_ITEMS-1:0] gray_of(input logic [N_ITEMS-1:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/knap_gray_enumerator_if.sv
// Solution stream from the enumerator to its consumer.
interface knap_gray_enumerator_if;
  import knap_pkg::*;

  // A beat transfers on a clock edge where sol_valid && sol_ready. While
  // sol_valid is high and sol_ready low, mask and value hold stable; valid
  // never depends on ready, and ready is ignored while valid is low.
  logic               sol_valid;
  logic               sol_ready;
  logic [N_ITEMS-1:0] sol_mask;
  logic [ACC_W-1:0]   sol_value;

  modport master (output sol_valid, output sol_mask, output sol_value, input sol_ready);
  modport slave  (input sol_valid, input sol_mask, input sol_value, output sol_ready);

endinterface

// File: rtl/knap_gray_step.sv
// Gray-code step: which mask bit flips when moving from idx to idx+1, and in which direction.
module knap_gray_step
  import knap_pkg::*;
(
  input  logic [N_ITEMS-1:0] i_idx,
  output logic [POS_W-1:0]   o_flip_pos,
  output logic               o_flip_up
);

  logic [N_ITEMS-1:0] w_next;
  logic [N_ITEMS-1:0] w_gray;
  logic [POS_W-1:0]   w_pos;

  assign w_next = i_idx + N_ITEMS'(1);
  assign w_gray = gray_of(i_idx);

  // Scanning downward leaves the lowest set bit: the trailing-zero count of idx+1.
  always_comb begin
    w_pos = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (w_next[i]) w_pos = POS_W'(i);
    end
  end

  assign o_flip_pos = w_pos;
  assign o_flip_up  = ~w_gray[w_pos];

endmodule

// File: rtl/knap_gray_enumerator.sv
// Walks all selection masks in Gray order with running totals and streams the feasible ones.
module knap_gray_enumerator
  import knap_pkg::*;
#(
  parameter logic [ACC_W-1:0] MIN_VALUE  = MIN_VALUE_DEF,
  parameter logic [ACC_W-1:0] MAX_WEIGHT = MAX_WEIGHT_DEF,
  parameter logic [ACC_W-1:0] MAX_VOLUME = MAX_VOLUME_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  knap_gray_enumerator_if.master sol,
  output logic [N_ITEMS:0]       sol_count,
  output logic [N_ITEMS-1:0]     best_mask,
  output logic [ACC_W-1:0]       best_value,
  output state_t                 dbg_state
);

  state_t             r_state;
  logic [N_ITEMS-1:0] r_idx;
  logic [N_ITEMS-1:0] r_mask;
  logic [ACC_W-1:0]   r_val;
  logic [ACC_W-1:0]   r_wt;
  logic [ACC_W-1:0]   r_vol;
  logic [N_ITEMS:0]   r_count;
  logic [N_ITEMS-1:0] r_best_mask;
  logic [ACC_W-1:0]   r_best_value;
  logic               r_busy;
  logic               r_done;

  logic [POS_W-1:0]   w_flip_pos;
  logic               w_flip_up;
  logic               w_feasible;
  logic               w_advance;
  logic               w_last;
  logic [ACC_W-1:0]   w_item_val;
  logic [ACC_W-1:0]   w_item_wt;
  logic [ACC_W-1:0]   w_item_vol;

  knap_gray_step u_step (
    .i_idx      (r_idx),
    .o_flip_pos (w_flip_pos),
    .o_flip_up  (w_flip_up)
  );

  assign w_item_val = ACC_W'(VALUE_TAB[w_flip_pos]);
  assign w_item_wt  = ACC_W'(WEIGHT_TAB[w_flip_pos]);
  assign w_item_vol = ACC_W'(VOLUME_TAB[w_flip_pos]);

  // Feasibility is judged purely from the registered totals of the current mask.
  assign w_feasible = (r_val >= MIN_VALUE) && (r_wt <= MAX_WEIGHT) && (r_vol <= MAX_VOLUME);
  assign w_advance  = (r_state == RUN) && (!w_feasible || sol.sol_ready);
  assign w_last     = &r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_mask       <= '0;
      r_val        <= '0;
      r_wt         <= '0;
      r_vol        <= '0;
      r_count      <= '0;
      r_best_mask  <= '0;
      r_best_value <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= INIT;
            r_busy  <= 1'b1;
          end
        end
        INIT: begin
          r_idx        <= '0;
          r_mask       <= '0;
          r_val        <= '0;
          r_wt         <= '0;
          r_vol        <= '0;
          r_count      <= '0;
          r_best_mask  <= '0;
          r_best_value <= '0;
          r_state      <= RUN;
        end
        RUN: begin
          if (w_advance) begin
            if (w_feasible) begin
              r_count <= r_count + (N_ITEMS + 1)'(1);
              // Strict compare keeps the earliest mask on a value tie.
              if (r_val > r_best_value) begin
                r_best_value <= r_val;
                r_best_mask  <= r_mask;
              end
            end
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx              <= r_idx + N_ITEMS'(1);
              r_mask[w_flip_pos] <= w_flip_up;
              if (w_flip_up) begin
                r_val <= r_val + w_item_val;
                r_wt  <= r_wt + w_item_wt;
                r_vol <= r_vol + w_item_vol;
              end else begin
                r_val <= r_val - w_item_val;
                r_wt  <= r_wt - w_item_wt;
                r_vol <= r_vol - w_item_vol;
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sol.sol_valid = (r_state == RUN) && w_feasible;
  assign sol.sol_mask  = r_mask;
  assign sol.sol_value = r_val;

  assign busy       = r_busy;
  assign done       = r_done;
  assign sol_count  = r_count;
  assign best_mask  = r_best_mask;
  assign best_value = r_best_value;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_knap_gray_enumerator.sv
// Bench: default-limit, backpressured and relaxed-limit enumerators run side by side against a table model.
module tb_knap_gray_enumerator;
  import knap_pkg::*;

  localparam int EW      = ACC_W + N_ITEMS;
  localparam int N_MASKS = 1 << N_ITEMS;
  localparam int RUN_CYC = 2 + N_MASKS;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic start;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  knap_gray_enumerator_if if_a ();
  knap_gray_enumerator_if if_b ();
  knap_gray_enumerator_if if_c ();

  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [N_ITEMS:0]   cnt_a, cnt_b, cnt_c;
  logic [N_ITEMS-1:0] bm_a, bm_b, bm_c;
  logic [ACC_W-1:0]   bv_a, bv_b, bv_c;
  state_t             st_a, st_b, st_c;

  knap_gray_enumerator u_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a), .sol(if_a),
    .sol_count(cnt_a), .best_mask(bm_a), .best_value(bv_a), .dbg_state(st_a));

  knap_gray_enumerator u_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b), .sol(if_b),
    .sol_count(cnt_b), .best_mask(bm_b), .best_value(bv_b), .dbg_state(st_b));

  knap_gray_enumerator #(.MIN_VALUE(12'd0), .MAX_WEIGHT(12'd4095), .MAX_VOLUME(12'd4095)) u_c (
    .clk(clk), .rst(rst), .start(start), .busy(busy_c), .done(done_c), .sol(if_c),
    .sol_count(cnt_c), .best_mask(bm_c), .best_value(bv_c), .dbg_state(st_c));

  logic [77:0] snap_a, snap_b, snap_c;
  assign snap_a = {busy_a, done_a, if_a.sol_valid, if_a.sol_mask, if_a.sol_value, cnt_a, bm_a, bv_a, st_a};
  assign snap_b = {busy_b, done_b, if_b.sol_valid, if_b.sol_mask, if_b.sol_value, cnt_b, bm_b, bv_b, st_b};
  assign snap_c = {busy_c, done_c, if_c.sol_valid, if_c.sol_mask, if_c.sol_value, cnt_c, bm_c, bv_c, st_c};

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0]      gold_q[$], all_q[$], exp_q_a[$], exp_q_b[$], exp_q_c[$];
  logic [N_ITEMS-1:0] cap_q[$];
  int                 gold_cnt = 0, gold_best = 0, all_best = 0;
  logic [N_ITEMS-1:0] gold_best_mask = '0, all_best_mask = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void totals(input logic [N_ITEMS-1:0] m, output int v, output int w, output int u);
    v = 0; w = 0; u = 0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (m[i]) begin
        v += int'(VALUE_TAB[i]);
        w += int'(WEIGHT_TAB[i]);
        u += int'(VOLUME_TAB[i]);
      end
    end
  endfunction

  // output monitors and the backpressure driver for u_b
  int phase = 0;
  int stall_cnt = 0, stall_sol = 0, n_beats_c = 0;
  int n_done_a = 0, n_done_b = 0, n_done_c = 0;
  int done_cyc_a = 0, done_cyc_b = 0, done_cyc_c = 0;
  int mv, mw, mu;
  logic [N_ITEMS-1:0] held_mask;
  logic [ACC_W-1:0]   held_val;
  logic [EW-1:0]      e;

  always @(negedge clk) begin
    if (phase != 2) begin
      if_b.sol_ready = 1'b1;
      if (phase == 1 && if_c.sol_valid && if_c.sol_ready && cap_q.size() < 50)
        cap_q.push_back(if_c.sol_mask);
    end else begin
      if (if_a.sol_valid && if_a.sol_ready) begin
        totals(if_a.sol_mask, mv, mw, mu);
        chk("a_feasible", {mv >= 120, mw <= 60, mu <= 60}, 3'b111);
        chk("a_value_tab", if_a.sol_value, mv);
        chk("a_q_nonempty", exp_q_a.size() != 0, 1);
        if (exp_q_a.size() != 0) begin
          e = exp_q_a.pop_front();
          chk("a_beat", {if_a.sol_value, if_a.sol_mask}, e);
        end
      end
      if (if_b.sol_valid) begin
        if (stall_sol < 3 && stall_cnt < 10) begin
          if (stall_cnt == 0) begin
            held_mask = if_b.sol_mask;
            held_val  = if_b.sol_value;
          end else begin
            chk("b_stall_hold", {if_b.sol_value, if_b.sol_mask}, {held_val, held_mask});
          end
          if_b.sol_ready = 1'b0;
          stall_cnt++;
        end else begin
          if_b.sol_ready = 1'b1;
          chk("b_q_nonempty", exp_q_b.size() != 0, 1);
          if (exp_q_b.size() != 0) begin
            e = exp_q_b.pop_front();
            chk("b_beat", {if_b.sol_value, if_b.sol_mask}, e);
          end
          if (stall_cnt == 10) begin
            chk("b_stall_release", {if_b.sol_value, if_b.sol_mask}, {held_val, held_mask});
            stall_cnt = 0;
            stall_sol++;
          end
        end
      end else begin
        if_b.sol_ready = 1'($urandom_range(0, 1));
      end
      if (if_c.sol_valid && if_c.sol_ready) begin
        chk("c_q_nonempty", exp_q_c.size() != 0, 1);
        if (exp_q_c.size() != 0) begin
          e = exp_q_c.pop_front();
          chk("c_beat", {if_c.sol_value, if_c.sol_mask}, e);
        end
        if (n_beats_c < cap_q.size()) chk("c_replay", if_c.sol_mask, cap_q[n_beats_c]);
        n_beats_c++;
      end
      if (done_a) begin n_done_a++; done_cyc_a = cyc; end
      if (done_b) begin n_done_b++; done_cyc_b = cyc; end
      if (done_c) begin n_done_c++; done_cyc_c = cyc; end
    end
  end

  int t0;
  int b_delay;
  logic [N_ITEMS-1:0] gm;
  int gv, gw, gu;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    if_a.sol_ready = 1'b1;
    if_c.sol_ready = 1'b1;

    // golden lists: feasible masks and every mask, both in Gray order
    for (int i = 0; i < N_MASKS; i++) begin
      gm = N_ITEMS'(i ^ (i >> 1));
      totals(gm, gv, gw, gu);
      all_q.push_back({ACC_W'(gv), gm});
      if (gv > all_best) begin all_best = gv; all_best_mask = gm; end
      if (gv >= 120 && gw <= 60 && gu <= 60) begin
        gold_q.push_back({ACC_W'(gv), gm});
        gold_cnt++;
        if (gv > gold_best) begin gold_best = gv; gold_best_mask = gm; end
      end
    end
    b_delay = 10 * ((gold_cnt < 3) ? gold_cnt : 3);

    repeat (3) @(negedge clk);
    chk("rst_a", snap_a, '0);
    chk("rst_b", snap_b, '0);
    chk("rst_c", snap_c, '0);
    rst = 1'b0;
    @(negedge clk);

    // first run, cut short by a mid-run reset
    start = 1'b1; t0 = cyc; phase = 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a", snap_a, '0);
    chk("midrst_b", snap_b, '0);
    chk("midrst_c", snap_c, '0);
    chk("cap_size", cap_q.size(), 50);
    rst = 1'b0; phase = 0;
    @(negedge clk);

    // full run with a stray start inside it
    exp_q_a = gold_q; exp_q_b = gold_q; exp_q_c = all_q;
    n_beats_c = 0; stall_cnt = 0; stall_sol = 0;
    start = 1'b1; t0 = cyc; phase = 2;
    @(negedge clk);
    start = 1'b0;
    while (!(n_done_a > 0 && n_done_b > 0 && n_done_c > 0) && cyc < t0 + RUN_CYC + 200) begin
      @(negedge clk);
      if (cyc == t0 + 100) begin
        chk("busy_mid", {busy_a, busy_b, busy_c}, 3'b111);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("all_done_seen", {n_done_a > 0, n_done_b > 0, n_done_c > 0}, 3'b111);
    repeat (3) @(negedge clk);

    chk("done_cyc_a", done_cyc_a - t0, RUN_CYC);
    chk("done_cyc_b", done_cyc_b - t0, RUN_CYC + b_delay);
    chk("done_cyc_c", done_cyc_c - t0, RUN_CYC);
    chk("done_pulses", {n_done_a[7:0], n_done_b[7:0], n_done_c[7:0]}, 24'h010101);
    chk("count_a", cnt_a, gold_cnt);
    chk("count_b", cnt_b, gold_cnt);
    chk("count_c", cnt_c, N_MASKS);
    chk("best_a", {bv_a, bm_a}, {ACC_W'(gold_best), gold_best_mask});
    chk("best_b", {bv_b, bm_b}, {ACC_W'(gold_best), gold_best_mask});
    chk("best_c", {bv_c, bm_c}, {ACC_W'(all_best), all_best_mask});
    chk("queues_drained", {exp_q_a.size(), exp_q_b.size(), exp_q_c.size()}, 96'd0);
    chk("c_beats", n_beats_c, N_MASKS);
    chk("idle_flags", {busy_a, done_a, if_a.sol_valid, busy_b, done_b, if_b.sol_valid,
                       busy_c, done_c, if_c.sol_valid}, 9'd0);
    chk("idle_state", {st_a, st_b, st_c}, {IDLE, IDLE, IDLE});
    phase = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
